player_motion_ctrl: RTL and testbench

// Per-frame player kinematics for Hollow_Knight: walk, jump with gravity, dash with cooldown.

---
 rtl/player_pkg.sv | 59 +++++
 rtl/player_key_decoder.sv | 48 ++++
 rtl/player_motion_ctrl.sv | 134 +++++++++++++
 tb/tb_player_motion_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the player motion block: state enum, key codes,
// Q.FRAC fixed-point type and the tuning constants pre-scaled to fixed point.
package player_pkg;

  localparam int FRAC        = 4;
  localparam int PX_W        = 10;
  localparam int FX_W        = PX_W + FRAC + 2;

  localparam int X_MAX       = 639;
  localparam int Y_MAX       = 479;
  localparam int SIZE_X      = 28;
  localparam int SIZE_Y      = 62;
  localparam int START_X     = 320;
  localparam int START_Y     = 417;
  localparam int RUN_V       = 32;
  localparam int JUMP_V      = 96;
  localparam int GRAVITY     = 4;
  localparam int VMAX_FALL   = 128;
  localparam int DASH_V      = 96;
  localparam int DASH_FRAMES = 8;
  localparam int DASH_CD     = 30;

  localparam int DC_W        = $clog2(DASH_FRAMES + 1);
  localparam int CD_W        = $clog2(DASH_CD + 1);

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_J = 8'h0D;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    JUMP = 3'd2,
    FALL = 3'd3,
    DASH = 3'd4
  } pstate_t;

  // Screen box and speeds in Q.FRAC units
  localparam fx_t X_LO_FX    = fx_t'(SIZE_X << FRAC);
  localparam fx_t X_HI_FX    = fx_t'((X_MAX - SIZE_X) << FRAC);
  localparam fx_t Y_LO_FX    = fx_t'(SIZE_Y << FRAC);
  localparam fx_t FLOOR_FX   = fx_t'((Y_MAX - SIZE_Y) << FRAC);
  localparam fx_t START_X_FX = fx_t'(START_X << FRAC);
  localparam fx_t START_Y_FX = fx_t'(START_Y << FRAC);
  localparam fx_t RUN_VX     = fx_t'(RUN_V);
  localparam fx_t JUMP_VY    = fx_t'(JUMP_V);
  localparam fx_t GRAV_VY    = fx_t'(GRAVITY);
  localparam fx_t VMAX_VY    = fx_t'(VMAX_FALL);
  localparam fx_t DASH_VX    = fx_t'(DASH_V);

  // Integer pixel part; positions are non-negative after clamping
  function automatic logic [PX_W-1:0] to_px(input fx_t v);
    return v[FRAC +: PX_W];
  endfunction

endpackage

// File: rtl/player_key_decoder.sv
// Scans all keycode slots for the movement keys and produces press-edge
// pulses for jump and dash from a registered copy of the previous frame.
module player_key_decoder
  import player_pkg::*;
#(
  parameter int KEY_SLOTS = 2
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  output logic                   left,
  output logic                   right,
  output logic                   jump_edge,
  output logic                   dash_edge
);

  logic [KEY_SLOTS-1:0] hit_a, hit_d, hit_w, hit_j;
  logic w_now, j_now;
  logic prev_w_reg, prev_j_reg;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_SLOTS; gi++) begin : g_slot
      assign hit_a[gi] = (keycode[8*gi +: 8] == KEY_A);
      assign hit_d[gi] = (keycode[8*gi +: 8] == KEY_D);
      assign hit_w[gi] = (keycode[8*gi +: 8] == KEY_W);
      assign hit_j[gi] = (keycode[8*gi +: 8] == KEY_J);
    end
  endgenerate

  assign left      = |hit_a;
  assign right     = |hit_d;
  assign w_now     = |hit_w;
  assign j_now     = |hit_j;
  assign jump_edge = w_now & ~prev_w_reg;
  assign dash_edge = j_now & ~prev_j_reg;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_w_reg <= 1'b0;
      prev_j_reg <= 1'b0;
    end else begin
      prev_w_reg <= w_now;
      prev_j_reg <= j_now;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player kinematics: walk, jump under gravity, dash with cooldown,
// integrated in Q.FRAC fixed point and clamped to the screen box.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int KEY_SLOTS = 2
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  output logic [PX_W-1:0]        PosX,
  output logic [PX_W-1:0]        PosY,
  output logic [PX_W-1:0]        SizeX,
  output logic [PX_W-1:0]        SizeY,
  output logic                   Facing,
  output logic                   Grounded,
  output pstate_t                State
);

  logic left, right, jump_edge, dash_edge;

  player_key_decoder #(.KEY_SLOTS(KEY_SLOTS)) u_keys (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .left      (left),
    .right     (right),
    .jump_edge (jump_edge),
    .dash_edge (dash_edge)
  );

  // Horizontal velocity is re-derived every frame, so only vy is stored
  fx_t px_reg, py_reg, vy_reg;
  fx_t px_next, py_next, vy_next;
  fx_t vx_new, vy_new, vy_base, vy_sum, px_sum, py_sum;
  pstate_t state_reg, state_next;
  logic facing_reg, facing_next, grounded_reg, grounded_next;
  logic [DC_W-1:0] dash_reg, dash_next;
  logic [CD_W-1:0] cd_reg, cd_next;
  logic dashing, start_dash, airborne, horiz, still_dash;

  always_comb begin
    dashing     = (state_reg == DASH);
    start_dash  = dash_edge && (cd_reg == '0) && !dashing;
    airborne    = (py_reg < FLOOR_FX);
    horiz       = left ^ right;
    facing_next = facing_reg;
    dash_next   = dash_reg;
    cd_next     = cd_reg;
    still_dash  = 1'b0;
    vx_new      = '0;
    vy_new      = '0;
    vy_base     = vy_reg;
    vy_sum      = '0;

    if (start_dash || dashing) begin
      vx_new = facing_reg ? -DASH_VX : DASH_VX;
      if (start_dash) begin
        dash_next  = DC_W'(DASH_FRAMES - 1);
        still_dash = (DASH_FRAMES > 1);
      end else begin
        dash_next  = dash_reg - DC_W'(1);
        still_dash = (dash_reg > DC_W'(1));
      end
      if (!still_dash) cd_next = CD_W'(DASH_CD);
    end else begin
      if (cd_reg != '0) cd_next = cd_reg - CD_W'(1);
      if (horiz) begin
        facing_next = left;
        vx_new      = right ? RUN_VX : -RUN_VX;
      end
      // Take-off frame already counts as airborne, so gravity applies to it too
      if (airborne || jump_edge) begin
        vy_base = (jump_edge && !airborne) ? -JUMP_VY : vy_reg;
        vy_sum  = vy_base + GRAV_VY;
        vy_new  = (vy_sum > VMAX_VY) ? VMAX_VY : vy_sum;
      end
    end

    px_sum = px_reg + vx_new;
    if (px_sum < X_LO_FX)      px_next = X_LO_FX;
    else if (px_sum > X_HI_FX) px_next = X_HI_FX;
    else                       px_next = px_sum;

    py_sum  = py_reg + vy_new;
    vy_next = vy_new;
    if (py_sum < Y_LO_FX) begin
      py_next = Y_LO_FX;
      vy_next = '0;
    end else if (py_sum >= FLOOR_FX) begin
      py_next = FLOOR_FX;
      vy_next = '0;
    end else begin
      py_next = py_sum;
    end

    grounded_next = (py_next == FLOOR_FX);
    if (still_dash)         state_next = DASH;
    else if (!grounded_next) state_next = (vy_next < 0) ? JUMP : FALL;
    else if (horiz)          state_next = RUN;
    else                     state_next = IDLE;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      px_reg       <= START_X_FX;
      py_reg       <= START_Y_FX;
      vy_reg       <= '0;
      state_reg    <= IDLE;
      facing_reg   <= 1'b0;
      grounded_reg <= 1'b1;
      dash_reg     <= '0;
      cd_reg       <= '0;
    end else begin
      px_reg       <= px_next;
      py_reg       <= py_next;
      vy_reg       <= vy_next;
      state_reg    <= state_next;
      facing_reg   <= facing_next;
      grounded_reg <= grounded_next;
      dash_reg     <= dash_next;
      cd_reg       <= cd_next;
    end
  end

  assign PosX     = to_px(px_reg);
  assign PosY     = to_px(py_reg);
  assign SizeX    = PX_W'(SIZE_X);
  assign SizeY    = PX_W'(SIZE_Y);
  assign Facing   = facing_reg;
  assign Grounded = grounded_reg;
  assign State    = state_reg;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios with literal pins plus random
// key traffic, all checked every frame against a pixel-arithmetic reference model.
module tb_player_motion_ctrl;
  import player_pkg::*;

  localparam int KS    = 2;
  localparam int FLOOR = 417 * 16;

  logic          frame_clk = 1'b0;
  logic          Reset     = 1'b1;
  logic [15:0]   keycode   = 16'h0;
  logic [9:0]    PosX, PosY, SizeX, SizeY;
  logic          Facing, Grounded;
  pstate_t       State;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Reference model state: position in 1/16 px, dash frames still to come
  int m_x, m_y, m_vy, m_face, m_dash, m_cd;
  bit m_pw, m_pj;
  pstate_t m_state;

  always #5 frame_clk = ~frame_clk;

  player_motion_ctrl #(.KEY_SLOTS(KS)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .PosX      (PosX),
    .PosY      (PosY),
    .SizeX     (SizeX),
    .SizeY     (SizeY),
    .Facing    (Facing),
    .Grounded  (Grounded),
    .State     (State)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 320 * 16; m_y = FLOOR; m_vy = 0; m_face = 0;
    m_dash = 0; m_cd = 0; m_pw = 1'b0; m_pj = 1'b0; m_state = IDLE;
  endtask

  task automatic model_step(input logic [15:0] kc);
    bit l, r, w, j, wedge, jedge, air;
    int vx, vy;
    logic [7:0] s;
    l = 0; r = 0; w = 0; j = 0;
    for (int k = 0; k < KS; k++) begin
      s = kc[8*k +: 8];
      if (s == 8'h04) l = 1;
      if (s == 8'h07) r = 1;
      if (s == 8'h1A) w = 1;
      if (s == 8'h0D) j = 1;
    end
    wedge = w && !m_pw;
    jedge = j && !m_pj;
    m_pw = w; m_pj = j;
    air = (m_y < FLOOR);
    vx = 0; vy = 0;
    if (m_dash > 0) begin
      vx = m_face ? -96 : 96;
      m_dash--;
      if (m_dash == 0) m_cd = 30;
    end else if (jedge && m_cd == 0) begin
      vx = m_face ? -96 : 96;
      m_dash = 7;
    end else begin
      if (m_cd > 0) m_cd--;
      if (l && !r) begin m_face = 1; vx = -32; end
      if (r && !l) begin m_face = 0; vx = 32; end
      if (wedge && !air) vy = -96 + 4;
      else if (air)      vy = (m_vy + 4 > 128) ? 128 : m_vy + 4;
    end
    m_x = m_x + vx;
    if (m_x < 28 * 16)  m_x = 28 * 16;
    if (m_x > 611 * 16) m_x = 611 * 16;
    m_y = m_y + vy;
    if (m_y < 62 * 16) begin m_y = 62 * 16; vy = 0; end
    if (m_y >= FLOOR)  begin m_y = FLOOR; vy = 0; end
    m_vy = vy;
    if (m_dash > 0)     m_state = DASH;
    else if (m_y < FLOOR) m_state = (vy < 0) ? JUMP : FALL;
    else                m_state = (l ^ r) ? RUN : IDLE;
  endtask

  always @(posedge frame_clk) begin
    if (Reset) model_reset();
    else       model_step(keycode);
  end

  always @(negedge frame_clk) begin
    if (cmp_en) begin
      check("PosX", int'(PosX), m_x / 16);
      check("PosY", int'(PosY), m_y / 16);
      check("State", int'(State), int'(m_state));
      check("Facing", int'(Facing), m_face);
      check("Grounded", int'(Grounded), (m_y == FLOOR) ? 1 : 0);
      check("SizeX", int'(SizeX), 28);
      check("SizeY", int'(SizeY), 62);
    end
  end

  task automatic frames(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  // Assert reset between edges, hold it across one posedge, release on a negedge
  task automatic do_reset();
    #2;
    Reset = 1'b1;
    model_reset();
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 7))
      0, 1:    return 8'h00;
      2:       return 8'h04;
      3:       return 8'h07;
      4:       return 8'h1A;
      5:       return 8'h0D;
      6:       return 8'h2C;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int hold;
    model_reset();
    frames(2);
    Reset  = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset
    frames(10);
    check("idle_x", int'(PosX), 320);
    check("idle_y", int'(PosY), 417);
    check("idle_state", int'(State), int'(IDLE));
    check("idle_gnd", int'(Grounded), 1);

    // Walk right, then A+D together
    keycode = {8'h00, 8'h07};
    frames(10);
    check("walk_x", int'(PosX), 340);
    check("walk_face", int'(Facing), 0);
    check("walk_state", int'(State), int'(RUN));
    keycode = {8'h04, 8'h07};
    frames(5);
    check("ad_x", int'(PosX), 340);
    check("ad_face", int'(Facing), 0);
    keycode = 16'h0;
    frames(1);

    // Jump arc
    keycode = {8'h1A, 8'h00};
    frames(1);
    check("jump1_y", int'(PosY), 411);
    check("jump1_state", int'(State), int'(JUMP));
    keycode = 16'h0;
    frames(22);
    check("jump23_state", int'(State), int'(JUMP));
    frames(1);
    check("apex24_state", int'(State), int'(FALL));
    frames(5);
    keycode = {8'h00, 8'h1A};
    frames(17);
    check("fall46_gnd", int'(Grounded), 0);
    frames(1);
    check("land47_y", int'(PosY), 417);
    check("land47_gnd", int'(Grounded), 1);
    check("land47_state", int'(State), int'(IDLE));
    frames(5);
    check("held_w_y", int'(PosY), 417);
    keycode = 16'h0;

    // Screen-edge clamps
    do_reset();
    keycode = {8'h00, 8'h07};
    frames(160);
    check("clamp_r", int'(PosX), 611);
    keycode = {8'h04, 8'h00};
    frames(300);
    check("clamp_l", int'(PosX), 28);
    check("clamp_l_face", int'(Facing), 1);
    keycode = 16'h0;

    // Dash and cooldown
    do_reset();
    keycode = {8'h00, 8'h0D};
    frames(1);
    check("dash1_state", int'(State), int'(DASH));
    check("dash1_x", int'(PosX), 326);
    keycode = 16'h0;
    frames(7);
    check("dash_end_x", int'(PosX), 368);
    check("dash_end_y", int'(PosY), 417);
    check("dash_end_state", int'(State), int'(IDLE));
    frames(4);
    keycode = {8'h0D, 8'h00};
    frames(1);
    check("cd_block_x", int'(PosX), 368);
    keycode = 16'h0;
    frames(24);
    keycode = {8'h00, 8'h0D};
    frames(1);
    check("cd_last_state", int'(State), int'(IDLE));
    keycode = 16'h0;
    frames(1);
    keycode = {8'h00, 8'h0D};
    frames(1);
    check("redash_state", int'(State), int'(DASH));
    keycode = 16'h0;
    frames(7);
    check("redash_x", int'(PosX), 416);

    // Asynchronous reset mid-dash and mid-jump
    do_reset();
    keycode = {8'h00, 8'h0D};
    frames(1);
    keycode = 16'h0;
    frames(2);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("rst_dash_x", int'(PosX), 320);
    check("rst_dash_state", int'(State), int'(IDLE));
    @(negedge frame_clk);
    Reset = 1'b0;
    keycode = {8'h1A, 8'h00};
    frames(1);
    keycode = 16'h0;
    frames(4);
    #2;
    Reset = 1'b1;
    model_reset();
    keycode = {8'h00, 8'h07};
    #1;
    check("rst_jump_y", int'(PosY), 417);
    check("rst_jump_gnd", int'(Grounded), 1);
    @(negedge frame_clk);
    Reset = 1'b0;
    frames(1);
    check("post_rst_x", int'(PosX), 322);
    check("post_rst_state", int'(State), int'(RUN));

    // Random key traffic with occasional resets
    hold = 0;
    for (int f = 0; f < 800; f++) begin
      if (hold == 0) begin
        keycode = {pick_key(), pick_key()};
        hold = $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 149) == 0) do_reset();
      else frames(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
